// File: rtl/sync_gen.sv
// Programmable sync-strobe generator: periodic o_sync pulse train for clock_sync.
// Optional external trigger gating via SYNC_GEN_EXT_TRIG_EN.
module sync_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WID_W = 8,
  parameter int unsigned NUM_W = 16
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [CNT_W-1:0] i_period,
  input  logic [WID_W-1:0] i_width,
  input  logic [NUM_W-1:0] i_burst,
  input  logic             i_start,
  input  logic             i_stop,
`ifdef SYNC_GEN_EXT_TRIG_EN
  input  logic             i_ext_trig,
`endif
  output logic             o_sync,
  output logic             o_busy,
  output logic             o_done,
  output logic [NUM_W-1:0] o_sync_num
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1
`ifdef SYNC_GEN_EXT_TRIG_EN
    ,S_WAIT_TRIG = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] sh_p_q, sh_p_d;
  logic [WID_W-1:0] sh_w_q, sh_w_d;
  logic [NUM_W-1:0] sh_n_q, sh_n_d;
  logic             stop_q, stop_d;
  logic             sync_q, sync_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] p_clamp;
  logic [WID_W-1:0] w_clamp;
  logic             cfg_take;
  logic             at_last;
  logic             go_run;

`ifdef SYNC_GEN_EXT_TRIG_EN
  // Two-flop synchronizer plus rising-edge detect for the asynchronous trigger pad
  logic trig_meta, trig_sync, trig_prev;
  logic trig_edge;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_meta <= 1'b0;
      trig_sync <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      trig_meta <= i_ext_trig;
      trig_sync <= trig_meta;
      trig_prev <= trig_sync;
    end
  end

  assign trig_edge = trig_sync & ~trig_prev;
`endif

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      num_q   <= '0;
      sh_p_q  <= CNT_W'(2);
      sh_w_q  <= WID_W'(1);
      sh_n_q  <= '0;
      stop_q  <= 1'b0;
      sync_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      num_q   <= num_d;
      sh_p_q  <= sh_p_d;
      sh_w_q  <= sh_w_d;
      sh_n_q  <= sh_n_d;
      stop_q  <= stop_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, config capture and next output values
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    num_d   = num_q;
    sh_p_d  = sh_p_q;
    sh_w_d  = sh_w_q;
    sh_n_d  = sh_n_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    go_run  = 1'b0;

    // Clamp so every pulse has at least one high and one low cycle
    p_clamp = (i_period < CNT_W'(2)) ? CNT_W'(2) : i_period;
    w_clamp = (i_width == '0) ? WID_W'(1) : i_width;
    if (CNT_W'(w_clamp) >= p_clamp) begin
      w_clamp = WID_W'(p_clamp - CNT_W'(1));
    end

    at_last  = (ph_q == (sh_p_q - CNT_W'(1)));
    cfg_take = i_cfg_valid && (state_q == S_IDLE);

    if (cfg_take) begin
      sh_p_d = p_clamp;
      sh_w_d = w_clamp;
      sh_n_d = i_burst;
    end

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (i_start && !i_stop) begin
`ifdef SYNC_GEN_EXT_TRIG_EN
          state_d = S_WAIT_TRIG;
          ph_d    = '0;
          num_d   = '0;
`else
          go_run  = 1'b1;
`endif
        end
      end
      S_RUN: begin
        if (i_stop) begin
          stop_d = 1'b1;
        end
        if (at_last) begin
          // Runs only end on a period boundary so no pulse is truncated
          if (stop_q || i_stop || ((sh_n_q != '0) && (num_q == sh_n_q))) begin
            state_d = S_IDLE;
            ph_d    = '0;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            ph_d  = '0;
            num_d = num_q + NUM_W'(1);
          end
        end else begin
          ph_d = ph_q + CNT_W'(1);
        end
      end
`ifdef SYNC_GEN_EXT_TRIG_EN
      S_WAIT_TRIG: begin
        if (i_stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (trig_edge) begin
          go_run = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (go_run) begin
      state_d = S_RUN;
      ph_d    = '0;
      num_d   = NUM_W'(1);
      stop_d  = 1'b0;
    end

    // Registered strobe tracks the phase being entered, using the config in force
    sync_d  = (state_d == S_RUN) && (ph_d < CNT_W'(sh_w_d));
    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
  end

  assign o_sync      = sync_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_cfg_ready = ready_q;
  assign o_sync_num  = num_q;

endmodule

// File: tb/tb_sync_gen.sv
// Directed, table-driven bench for sync_gen.
module tb_sync_gen;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        i_cfg_valid;
  logic        o_cfg_ready;
  logic [15:0] i_period;
  logic [7:0]  i_width;
  logic [15:0] i_burst;
  logic        i_start;
  logic        i_stop;
  logic        o_sync;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_sync_num;
`ifdef SYNC_GEN_EXT_TRIG_EN
  logic        i_ext_trig;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 sys_clk = ~sys_clk;

  sync_gen #(.CNT_W(16), .WID_W(8), .NUM_W(16)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_period    (i_period),
    .i_width     (i_width),
    .i_burst     (i_burst),
    .i_start     (i_start),
    .i_stop      (i_stop),
`ifdef SYNC_GEN_EXT_TRIG_EN
    .i_ext_trig  (i_ext_trig),
`endif
    .o_sync      (o_sync),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_sync_num  (o_sync_num)
  );

  typedef struct {
    logic        cfg_valid;
    logic [15:0] period;
    logic [7:0]  width;
    logic [15:0] burst;
    logic        start;
    logic        stop;
    logic        exp_sync;
    logic        exp_busy;
    logic        exp_done;
    logic [15:0] exp_num;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(logic cv, int p, int w, int n, logic st, logic sp,
                              logic es, logic eb, logic ed, int en);
    vec_t v;
    v.cfg_valid = cv;
    v.period    = 16'(p);
    v.width     = 8'(w);
    v.burst     = 16'(n);
    v.start     = st;
    v.stop      = sp;
    v.exp_sync  = es;
    v.exp_busy  = eb;
    v.exp_done  = ed;
    v.exp_num   = 16'(en);
    return v;
  endfunction

  // Packed view {sync, busy, done, ready, num}; ready is always the complement of busy
  function automatic logic [31:0] expv(logic s, logic b, logic d, logic [15:0] n);
    return {12'd0, s, b, d, ~b, n};
  endfunction

  function automatic logic [31:0] obs();
    return {12'd0, o_sync, o_busy, o_done, o_cfg_ready, o_sync_num};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h ({sync,busy,done,ready,num})", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_cfg_valid = 1'b0;
    i_period    = '0;
    i_width     = '0;
    i_burst     = '0;
    i_start     = 1'b0;
    i_stop      = 1'b0;
  endtask

  task automatic set_cfg(input int p, input int w, input int n);
    i_cfg_valid = 1'b1;
    i_period    = 16'(p);
    i_width     = 8'(w);
    i_burst     = 16'(n);
  endtask

  // Called in the cycle after start acceptance for P=10, W=3, N=4
  task automatic check_burst(input string tag);
    for (int k = 1; k <= 45; k++) begin
      logic        s, b, d;
      logic [15:0] n;
      b = (k <= 40);
      s = b && (((k - 1) % 10) < 3);
      d = (k == 41);
      n = b ? 16'((k - 1) / 10 + 1) : 16'd4;
      check($sformatf("%s_k%0d", tag, k), obs(), expv(s, b, d, n));
      if (k < 45) tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
`ifdef SYNC_GEN_EXT_TRIG_EN
    i_ext_trig = 1'b0;
`endif
    // Clamp rows (P=1,W=0 -> P=2,W=1; W=20 -> W=9), busy handshake, start+stop in IDLE
    vecs[0]  = mk(1, 1, 0, 0, 1, 0,  1, 1, 0, 1);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 2);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 2);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 3);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 3);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 3);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
    vecs[8]  = mk(1, 10, 20, 1, 1, 0, 1, 1, 0, 1);
    for (int i = 9; i <= 16; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1);
    vecs[19] = mk(1, 4, 2, 2, 1, 0,  1, 1, 0, 1);
    vecs[20] = mk(1, 20, 1, 0, 0, 0, 1, 1, 0, 1);
    vecs[21] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1);
    vecs[22] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 1);
    vecs[23] = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 2);
    vecs[24] = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 2);
    vecs[25] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 2);
    vecs[26] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 2);
    vecs[27] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 2);
    vecs[28] = mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 2);
    vecs[29] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 2);

    #12;
    check("reset_state", obs(), expv(0, 0, 0, 16'd0));
    #11 rst_n = 1'b1;
    tick();
    check("post_reset_idle", obs(), expv(0, 0, 0, 16'd0));

    // Burst P=10 W=3 N=4, config loaded before the start strobe
    set_cfg(10, 3, 4);
    tick();
    idle_inputs();
    check("cfg_load_idle", obs(), expv(0, 0, 0, 16'd0));
    i_start = 1'b1;
    tick();
    idle_inputs();
    check_burst("burst");

    for (int i = 0; i < 30; i++) begin
      i_cfg_valid = vecs[i].cfg_valid;
      i_period    = vecs[i].period;
      i_width     = vecs[i].width;
      i_burst     = vecs[i].burst;
      i_start     = vecs[i].start;
      i_stop      = vecs[i].stop;
      tick();
      idle_inputs();
      check($sformatf("vec%0d", i), obs(),
            expv(vecs[i].exp_sync, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_num));
    end

    // Graceful stop: continuous P=8 W=4, stop at ph=1 of the third pulse
    set_cfg(8, 4, 0);
    i_start = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k <= 28; k++) begin
      logic        s, b, d;
      logic [15:0] n;
      b = (k <= 24);
      s = b && (((k - 1) % 8) < 4);
      d = (k == 25);
      n = b ? 16'((k - 1) / 8 + 1) : 16'd3;
      check($sformatf("stop_k%0d", k), obs(), expv(s, b, d, n));
      i_stop = (k == 18);
      tick();
      i_stop = 1'b0;
    end

    // Asynchronous reset while o_sync is high
    set_cfg(6, 3, 0);
    i_start = 1'b1;
    tick();
    idle_inputs();
    check("rst_pre", obs(), expv(1, 1, 0, 16'd1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", obs(), expv(0, 0, 0, 16'd0));
    #3 rst_n = 1'b1;
    tick();
    check("rst_idle", obs(), expv(0, 0, 0, 16'd0));
    // Default config after reset: P=2, W=1, continuous
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("dflt_c1", obs(), expv(1, 1, 0, 16'd1));
    tick();
    check("dflt_c2", obs(), expv(0, 1, 0, 16'd1));
    tick();
    check("dflt_c3", obs(), expv(1, 1, 0, 16'd2));
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    check("dflt_c4", obs(), expv(0, 1, 0, 16'd2));
    tick();
    check("dflt_done", obs(), expv(0, 0, 1, 16'd2));
    tick();
    check("dflt_idle", obs(), expv(0, 0, 0, 16'd2));

`ifdef SYNC_GEN_EXT_TRIG_EN
    begin
      int cnt;
      set_cfg(10, 3, 4);
      i_start = 1'b1;
      tick();
      idle_inputs();
      for (int k = 0; k < 50; k++) begin
        check($sformatf("ext_wait%0d", k), obs(), expv(0, 1, 0, 16'd0));
        if (k < 49) tick();
      end
      tick();
      i_ext_trig = 1'b1;
      cnt = 0;
      while (o_sync !== 1'b1 && cnt < 8) begin
        tick();
        cnt++;
      end
      check("ext_latency", 32'(cnt >= 3 && cnt <= 4), 32'd1);
      check_burst("ext_burst");
      i_ext_trig = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("ext_wait_again", obs(), expv(0, 1, 0, 16'd0));
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      check("ext_stop_done", obs(), expv(0, 0, 1, 16'd0));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_gen.md
Name: sync_gen

Overview:
- Programmable sync-strobe generator in the sys_clk domain.
- Produces the periodic o_sync pulse train consumed directly by clock_sync's i_sync input, which re-times it into the hi_clk/adc_clk domains.
- Period, pulse width and burst length are loaded through a valid/ready config handshake; runs are started and stopped by strobes.
- Guarantees every pulse is at least 1 cycle high and at least 1 cycle low, which clock_sync requires.

Parameters:
- CNT_W, 16, width of the period counter (period in sys_clk cycles).
- WID_W, 8, width of the pulse-width field.
- NUM_W, 16, width of the burst-length field and the pulse counter.

Ports:
- sys_clk  in  1  single block clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- i_cfg_valid  in  1  config present.
- o_cfg_ready  out  1  config accepted when high (IDLE only).
- i_period  in  CNT_W  period P in cycles.
- i_width  in  WID_W  high time W in cycles.
- i_burst  in  NUM_W  pulse count N; 0 = continuous.
- i_start  in  1  start strobe.
- i_stop  in  1  graceful stop strobe.
- o_sync  out  1  registered sync strobe to clock_sync i_sync.
- o_busy  out  1  high outside IDLE.
- o_done  out  1  one-cycle pulse when a run ends.
- o_sync_num  out  NUM_W  pulses emitted in the current run.

Behaviour:
- Clock and reset: one clock, sys_clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - o_sync=0, o_busy=0, o_done=0, o_sync_num=0, o_cfg_ready=1.
  - Shadow config P=2, W=1, N=0; state IDLE.
- States:
  - IDLE, RUN, plus WAIT_TRIG (macro only).
  - o_cfg_ready = (state==IDLE); o_busy = !o_cfg_ready.
- Config:
  - Captured into shadow regs on i_cfg_valid && o_cfg_ready.
  - Clamping applied at capture:
    - P<2 gives P=2.
    - W=0 gives W=1.
    - W>=P gives W=P-1.
  - While busy, ready is low and config inputs are ignored.
- Start:
  - i_start in IDLE (without i_stop in the same cycle) goes to RUN next cycle.
  - Phase counter ph=0, o_sync_num=0.
  - If i_cfg_valid and i_start coincide in IDLE, the new config is used for this run.
- RUN:
  - ph counts 0..P-1 and wraps to 0.
  - o_sync is high exactly when ph<W; latency 1 cycle from start acceptance to first o_sync high.
  - o_sync_num increments on the cycle o_sync rises (ph==0).
  - Continuous mode wraps o_sync_num mod 2^NUM_W.
- Burst end: at ph==P-1 with o_sync_num==N (N!=0):
  - Next cycle: state IDLE, o_done=1 for one cycle, o_sync=0.
  - o_sync_num holds its final value until the next start.
- Stop:
  - i_stop in RUN is latched as a pending stop.
  - The run ends at the next ph==P-1 with the same o_done behaviour.
  - Pulses are never truncated.
  - i_stop in IDLE has no effect. i_start together with i_stop in IDLE: stop wins, stay IDLE.
- i_start in RUN: ignored.
- Reset mid-run: outputs return to reset values immediately (asynchronous); no o_done is generated.
- Arithmetic: ph is CNT_W bits; the W comparison zero-extends W to CNT_W.

Optional Feature:
- Macro: SYNC_GEN_EXT_TRIG_EN.
- Defined:
  - Adds port i_ext_trig (in, 1), asynchronous.
  - i_ext_trig passes through a 2-flop synchronizer plus rising-edge detect.
  - i_start moves IDLE to WAIT_TRIG (o_busy=1, o_sync=0).
  - The detected edge moves WAIT_TRIG to RUN, with o_sync high 1 cycle after the detected-edge cycle (3-4 cycles after the pad edge).
  - i_stop in WAIT_TRIG returns to IDLE next cycle with an o_done pulse.
- Not defined: no port and no WAIT_TRIG state; start behaves as described above.

Test Plan:
- Burst:
  - Stimulus: cfg P=10, W=3, N=4; i_start at cycle t.
  - Response: o_sync high t+1..t+3, t+11..t+13, t+21..t+23, t+31..t+33; o_done at t+41 only; o_sync_num=4; o_busy low from t+41.
- Clamping:
  - Stimulus: cfg P=1, W=0, N=0, then start.
  - Response: o_sync toggles 1,0,1,0 every cycle.
  - Stimulus: cfg P=10, W=20.
  - Response: o_sync high 9 cycles, low 1 cycle.
- Graceful stop:
  - Stimulus: continuous P=8, W=4; i_stop pulsed at ph=1 of the 3rd pulse.
  - Response: 3rd pulse completes at full width; o_done 1 cycle after ph=7; o_sync_num=3.
- Handshake:
  - Stimulus: cfg_valid with P=20 during RUN.
  - Response: o_cfg_ready=0 and period stays unchanged.
  - Stimulus: i_start+i_stop together in IDLE.
  - Response: no o_sync, o_busy stays 0.
- Reset mid-run:
  - Stimulus: rst_n low while o_sync=1.
  - Response: o_sync, o_busy, o_sync_num go to 0 without waiting for a clock edge; after release, stays IDLE with config P=2, W=1, N=0.
- Ext trigger (SYNC_GEN_EXT_TRIG_EN):
  - Stimulus: start, then i_ext_trig rises 50 cycles later.
  - Response: o_sync stays 0 until 3-4 cycles after the edge; burst then runs as in the burst scenario.
